// File: rtl/ad9361_cfg_seq.sv
// ad9361_cfg_seq: table-driven AD9361 configuration sequencer.
// Walks ROM words (WR/POLL/WAIT/END) and drives the SPI driver handshake.
module ad9361_cfg_seq #(
  parameter int ROM_AW     = 12,
  parameter int NFLAG      = 16,
  parameter int TICK_DIV   = 20,
  parameter int POLL_MAX   = 1000,
  parameter int POLL_GAP   = 1000,
  parameter bit AUTO_START = 1'b1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [25:0]       rom_data,
  output logic [9:0]        spi_addr,
  output logic [7:0]        spi_wdata,
  output logic              spi_wr_rdn,
  output logic              spi_req,
  input  logic              spi_busy,
  input  logic [7:0]        spi_rdata,
  input  logic              spi_rdata_en,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [ROM_AW-1:0] err_index,
  output logic [NFLAG-1:0]  flags,
  output logic [ROM_AW-1:0] cur_index
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_LATCH  = 4'd2;
  localparam logic [3:0] S_DECODE = 4'd3;
  localparam logic [3:0] S_ISSUE  = 4'd4;
  localparam logic [3:0] S_ACK    = 4'd5;
  localparam logic [3:0] S_RDWAIT = 4'd6;
  localparam logic [3:0] S_CHECK  = 4'd7;
  localparam logic [3:0] S_DELAY  = 4'd8;
  localparam logic [3:0] S_NEXT   = 4'd9;
  localparam logic [3:0] S_DONE   = 4'd10;
  localparam logic [3:0] S_ERR    = 4'd11;

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_POLL = 2'b01;
  localparam logic [1:0] OP_WAIT = 2'b10;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] ATT_LAST = PW'(POLL_MAX - 1);
  localparam logic [ROM_AW-1:0] IDX_LAST = '1;

  logic [3:0]        state_q, state_d;
  logic [ROM_AW-1:0] idx_q, idx_d;
  logic [25:0]       word_q, word_d;
  logic [PW-1:0]     att_q, att_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [23:0]       dly_q, dly_d;
  logic              retry_q, retry_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [9:0]        spi_addr_q, spi_addr_d;
  logic [7:0]        spi_wdata_q, spi_wdata_d;
  logic              spi_wr_q, spi_wr_d;
  logic              spi_req_q, spi_req_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ROM_AW-1:0] eidx_q, eidx_d;
  logic [NFLAG-1:0]  flags_q, flags_d;
  logic              armed_q, armed_d;

  logic [1:0] op;
  logic [9:0] f_addr;
  logic [7:0] f_lo;
  logic       f_pol;
  logic [4:0] f_id;
  logic       pass;
  logic       launch;

  assign op     = word_q[25:24];
  assign f_addr = word_q[17:8];
  assign f_lo   = word_q[7:0];
  assign f_pol  = word_q[23];
  assign f_id   = word_q[22:18];
  assign pass   = ((rdata_q & f_lo) == (f_pol ? f_lo : 8'h00));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    word_d      = word_q;
    att_d       = att_q;
    tick_d      = tick_q;
    dly_d       = dly_q;
    retry_d     = retry_q;
    rdata_d     = rdata_q;
    spi_addr_d  = spi_addr_q;
    spi_wdata_d = spi_wdata_q;
    spi_wr_d    = spi_wr_q;
    spi_req_d   = spi_req_q;
    done_d      = done_q;
    err_d       = err_q;
    eidx_d      = eidx_q;
    flags_d     = flags_q;
    armed_d     = armed_q;
    launch      = 1'b0;
    unique case (state_q)
      S_IDLE:  launch = start | armed_q;
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        word_d  = rom_data;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (op)
          OP_WR, OP_POLL: state_d = S_ISSUE;
          OP_WAIT: begin
            if (word_q[23:0] == 24'd0) begin
              state_d = S_NEXT;
            end else begin
              dly_d   = word_q[23:0];
              tick_d  = '0;
              retry_d = 1'b0;
              state_d = S_DELAY;
            end
          end
          default: begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        endcase
      end
      S_ISSUE: begin
        if (!spi_busy) begin
          spi_addr_d  = f_addr;
          spi_wdata_d = f_lo;
          spi_wr_d    = (op == OP_WR);
          spi_req_d   = 1'b1;
          state_d     = S_ACK;
        end
      end
      S_ACK: begin
        if (spi_busy) begin
          spi_req_d = 1'b0;
          state_d   = (op == OP_WR) ? S_NEXT : S_RDWAIT;
        end
      end
      S_RDWAIT: begin
        if (spi_rdata_en) begin
          rdata_d = spi_rdata;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (pass) begin
          // ids beyond NFLAG match no bit, so the flag write is dropped
          for (int i = 0; i < NFLAG; i++) begin
            if (f_id == 5'(i)) flags_d[i] = 1'b1;
          end
          state_d = S_NEXT;
        end else if (att_q < ATT_LAST) begin
          att_d = att_q + 1'b1;
          if (POLL_GAP == 0) begin
            state_d = S_ISSUE;
          end else begin
            dly_d   = 24'(POLL_GAP);
            tick_d  = '0;
            retry_d = 1'b1;
            state_d = S_DELAY;
          end
        end else begin
          err_d   = 1'b1;
          eidx_d  = idx_q;
          state_d = S_ERR;
        end
      end
      S_DELAY: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          dly_d  = dly_q - 24'd1;
          if (dly_q == 24'd1) state_d = retry_q ? S_ISSUE : S_NEXT;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_NEXT: begin
        att_d = '0;
        if (idx_q == IDX_LAST) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DONE, S_ERR: launch = start;
      default: state_d = S_IDLE;
    endcase
    if (launch) begin
      flags_d = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      eidx_d  = '0;
      idx_d   = '0;
      att_d   = '0;
      armed_d = 1'b0;
      state_d = S_FETCH;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      word_q      <= '0;
      att_q       <= '0;
      tick_q      <= '0;
      dly_q       <= '0;
      retry_q     <= 1'b0;
      rdata_q     <= '0;
      spi_addr_q  <= '0;
      spi_wdata_q <= '0;
      spi_wr_q    <= 1'b0;
      spi_req_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      eidx_q      <= '0;
      flags_q     <= '0;
      armed_q     <= AUTO_START;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      att_q       <= att_d;
      tick_q      <= tick_d;
      dly_q       <= dly_d;
      retry_q     <= retry_d;
      rdata_q     <= rdata_d;
      spi_addr_q  <= spi_addr_d;
      spi_wdata_q <= spi_wdata_d;
      spi_wr_q    <= spi_wr_d;
      spi_req_q   <= spi_req_d;
      done_q      <= done_d;
      err_q       <= err_d;
      eidx_q      <= eidx_d;
      flags_q     <= flags_d;
      armed_q     <= armed_d;
    end
  end

  assign rom_addr   = idx_q;
  assign cur_index  = idx_q;
  assign spi_addr   = spi_addr_q;
  assign spi_wdata  = spi_wdata_q;
  assign spi_wr_rdn = spi_wr_q;
  assign spi_req    = spi_req_q;
  assign cfg_done   = done_q;
  assign cfg_err    = err_q;
  assign err_index  = eidx_q;
  assign flags      = flags_q;
  assign cfg_busy   = !((state_q == S_IDLE) || (state_q == S_DONE) ||
                        (state_q == S_ERR));

endmodule
